lcd_debug_panel: RTL and testbench
==================================

# lcd_debug_panel

Parametrised, clocked debug text screen for the LCD character pipeline: shows NUM_VALUES registers of VALUE_WIDTH bits as grouped hex, plus a title line with a frame counter. Values are snapshotted once per frame so a row never tears mid-scan. Character lookup is a 2-stage pipeline with valid. Sits between the LCD scan/timing generator (column/row requests) and the font ROM.

## Interface
- NUM_VALUES, 3, registers displayed (1..16)
- VALUE_WIDTH, 32, bits per register; multiple of 4, 4..64
- FIRST_ROW, 2, row of value 0; value k on row FIRST_ROW+k
- HOLD_FRAMES, 30, frames a changed value stays highlighted (1..255)

- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- frame_start  in  1  one-cycle strobe at start of each frame
- freeze  in  1  1 = keep current snapshot
- values  in  NUM_VALUES*VALUE_WIDTH  value k at bits [k*VALUE_WIDTH +: VALUE_WIDTH]
- req_valid  in  1  column/row request this cycle
- column  in  7  character column
- row  in  6  character row
- char_valid  out  1  character/highlight valid
- character  out  7  ASCII/font code
- highlight  out  1  render inverse

## Operation
- Snapshot: on frame_start with freeze=0, snapshot[k] <= values[k] for all k. freeze=1 holds snapshot.
- Frame counter: 16-bit, +1 on every frame_start (freeze ignored), wraps 0xFFFF->0x0000.
- Digit layout: NDIG = VALUE_WIDTH/4; digit i (0 = most significant) at column i + i/4 (space after every 4 digits). Columns outside digits -> 0x20.
- Row 0 (title): col0-4 "Alice" (0x41 0x6C 0x69 0x63 0x65), col6 0x34, col8 0x03, col10-13 frame counter hex MSB first, else 0x20.
- Rows FIRST_ROW..FIRST_ROW+NUM_VALUES-1: hex of snapshot digit, uppercase ('0'-'9' 0x30-0x39, 'A'-'F' 0x41-0x46).
- All other rows: 0x20. highlight=0 on all non-value rows and on value-row spaces.

## Timing
- Latency 2: request accepted in cycle N -> char_valid=1 with result in N+2. Fully pipelined, one request per cycle, no backpressure.
- req_valid=0 in N -> char_valid=0 in N+2; character holds last value.
- frame_start and req_valid in same cycle: that request sees the old snapshot/counter; requests from N+1 see new ones.
- Reset: snapshot all 0, frame counter 0, hold counters 0, pipeline valids 0, char_valid=0, character=0x20, highlight=0. Reset mid-pipeline discards in-flight requests.
- Title counter digits sampled in stage 1 together with the snapshot.

## Configuration
- LCD_DEBUG_HIGHLIGHT_EN defined: per-value 8-bit hold counter. On snapshot-updating frame_start: if values[k] != snapshot[k], counter[k] <= HOLD_FRAMES; else if counter[k]!=0, decrement. Frozen frame_start: counters hold. highlight=1 for digit characters of value k while counter[k]!=0.
- Not defined: no counters, highlight constant 0, latency unchanged.

## Structure
- Package lcd_debug_pkg: character constants (space, heart, title string), hex-to-ASCII function, digit-column mapping function (column -> digit index/valid for given NDIG), FRAME_COUNTER_WIDTH=16.
- One sub-module: lcd_hex_digit (4-bit nybble -> 7-bit ASCII, combinational), instanced in stage 2.
- Parameter checks (VALUE_WIDTH%4, ranges) as elaboration-time assertions.

## Test plan
- Reset, values[0]=0x12345678, one frame_start, request row 2 col 0..9 -> chars "1234 5678" + 0x20 at cycles N+2, char_valid each cycle.
- VALUE_WIDTH=16, NUM_VALUES=5: value 4 = 0xBEEF on row 6 col 0..3 -> "BEEF"; row 7 -> 0x20.
- Title: 3 frame_starts then row 0 col 0..13 -> "Alice 4 " 0x03 " 0003"; 0x10000 frames -> "0000".
- freeze=1, change values[1] 0x0->0xFFFFFFFF, frame_start -> row 3 still "0000 0000"; freeze=0, frame_start -> "FFFF FFFF".
- Highlight build, HOLD_FRAMES=2: change value 0 then 3 unchanged frames -> highlight=1 on row 2 digits for 2 frames, 0 on third; spaces at col4 highlight=0.
- Request burst with req_valid gaps and reset asserted mid-burst -> char_valid tracks req_valid delayed by 2; after reset no stale char_valid.

Source files
------------

// File: rtl/lcd_debug_pkg.sv
// ============================================================================
// lcd_debug_pkg : character constants and lookup helpers for the debug panel
// Rev 1.0
// ============================================================================
`default_nettype none

package lcd_debug_pkg;

   localparam int FRAME_COUNTER_WIDTH = 16;

   localparam logic [6:0] CHAR_SPACE = 7'h20;
   localparam logic [6:0] CHAR_HEART = 7'h03;
   localparam logic [6:0] CHAR_FOUR  = 7'h34;

   localparam int          TITLE_LEN = 5;
   localparam logic [34:0] TITLE_STR = {7'h41, 7'h6C, 7'h69, 7'h63, 7'h65};

   typedef struct packed {
      logic       valid;
      logic [3:0] index;
   } digit_pos_t;

   function automatic logic [6:0] hex_to_ascii(input logic [3:0] nybble);
      return (nybble < 4'd10) ? 7'h30 + {3'b000, nybble} : 7'h37 + {3'b000, nybble};
   endfunction

   function automatic logic [6:0] title_char(input logic [2:0] index);
      return TITLE_STR[(TITLE_LEN - 1 - int'(index)) * 7 +: 7];
   endfunction

   // Digits come in groups of four separated by one blank column.
   function automatic digit_pos_t digit_pos(input logic [6:0] column, input int ndig);
      digit_pos_t pos;
      int         group;
      int         slot;
      int         index;
      group     = int'(column) / 5;
      slot      = int'(column) % 5;
      index     = group * 4 + slot;
      pos.valid = (slot != 4) && (index < ndig);
      pos.index = 4'(index);
      return pos;
   endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_hex_digit.sv
// ============================================================================
// lcd_hex_digit : 4-bit nybble to uppercase ASCII hex character
// Rev 1.0
// ============================================================================
`default_nettype none

module lcd_hex_digit
   import lcd_debug_pkg::*;
(
   input  logic [3:0] nybble,
   output logic [6:0] ascii
);

   assign ascii = hex_to_ascii(nybble);

endmodule

`default_nettype wire

// File: rtl/lcd_debug_panel.sv
// ============================================================================
// lcd_debug_panel : hex register debug screen with title/frame counter, 2-stage
// character lookup. Define LCD_DEBUG_HIGHLIGHT_EN for change highlighting.
// Rev 1.0
// ============================================================================
`default_nettype none

module lcd_debug_panel
   import lcd_debug_pkg::*;
#(
   parameter int NUM_VALUES  = 3,
   parameter int VALUE_WIDTH = 32,
   parameter int FIRST_ROW   = 2,
   parameter int HOLD_FRAMES = 30
)(
   input  logic                              clock,
   input  logic                              reset,
   input  logic                              frame_start,
   input  logic                              freeze,
   input  logic [NUM_VALUES*VALUE_WIDTH-1:0] values,
   input  logic                              req_valid,
   input  logic [6:0]                        column,
   input  logic [5:0]                        row,
   output logic                              char_valid,
   output logic [6:0]                        character,
   output logic                              highlight
);

   localparam int NDIG = VALUE_WIDTH / 4;

   if ((VALUE_WIDTH % 4) != 0 || VALUE_WIDTH < 4 || VALUE_WIDTH > 64) begin : g_bad_width
      $error("lcd_debug_panel: VALUE_WIDTH must be a multiple of 4 in 4..64");
   end
   if (NUM_VALUES < 1 || NUM_VALUES > 16) begin : g_bad_count
      $error("lcd_debug_panel: NUM_VALUES must be in 1..16");
   end
   if (HOLD_FRAMES < 1 || HOLD_FRAMES > 255) begin : g_bad_hold
      $error("lcd_debug_panel: HOLD_FRAMES must be in 1..255");
   end

   logic [VALUE_WIDTH-1:0]         snapshot [NUM_VALUES];
   logic [FRAME_COUNTER_WIDTH-1:0] frame_count;
   logic [NUM_VALUES-1:0]          hold_active;

   always_ff @(posedge clock) begin
      if (reset) begin
         frame_count <= '0;
         for (int k = 0; k < NUM_VALUES; k++) snapshot[k] <= '0;
      end else if (frame_start) begin
         frame_count <= frame_count + 1'b1;
         if (!freeze) begin
            for (int k = 0; k < NUM_VALUES; k++)
               snapshot[k] <= values[k*VALUE_WIDTH +: VALUE_WIDTH];
         end
      end
   end

`ifdef LCD_DEBUG_HIGHLIGHT_EN
   logic [7:0] hold_count [NUM_VALUES];

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int k = 0; k < NUM_VALUES; k++) hold_count[k] <= 8'd0;
      end else if (frame_start && !freeze) begin
         for (int k = 0; k < NUM_VALUES; k++) begin
            if (values[k*VALUE_WIDTH +: VALUE_WIDTH] != snapshot[k])
               hold_count[k] <= 8'(HOLD_FRAMES);
            else if (hold_count[k] != 8'd0)
               hold_count[k] <= hold_count[k] - 8'd1;
         end
      end
   end

   for (genvar k = 0; k < NUM_VALUES; k++) begin : g_hold_active
      assign hold_active[k] = (hold_count[k] != 8'd0);
   end
`else
   assign hold_active = '0;
`endif

   // Stage 1: decode the request and capture the nybble or literal character.
   logic       w_is_hex;
   logic       w_hl;
   logic [3:0] w_nybble;
   logic [6:0] w_char;
   digit_pos_t w_pos;

   always_comb begin
      w_is_hex = 1'b0;
      w_hl     = 1'b0;
      w_nybble = 4'd0;
      w_char   = CHAR_SPACE;
      w_pos    = digit_pos(column, NDIG);
      if (row == 6'd0) begin
         if (column < 7'd5) begin
            w_char = title_char(column[2:0]);
         end else if (column == 7'd6) begin
            w_char = CHAR_FOUR;
         end else if (column == 7'd8) begin
            w_char = CHAR_HEART;
         end else begin
            case (column)
               7'd10:   begin w_is_hex = 1'b1; w_nybble = frame_count[15:12]; end
               7'd11:   begin w_is_hex = 1'b1; w_nybble = frame_count[11:8];  end
               7'd12:   begin w_is_hex = 1'b1; w_nybble = frame_count[7:4];   end
               7'd13:   begin w_is_hex = 1'b1; w_nybble = frame_count[3:0];   end
               default: w_is_hex = 1'b0;
            endcase
         end
      end else begin
         for (int k = 0; k < NUM_VALUES; k++) begin
            if (int'(row) == FIRST_ROW + k && w_pos.valid) begin
               w_is_hex = 1'b1;
               w_hl     = hold_active[k];
               w_nybble = 4'(snapshot[k] >> (4 * (NDIG - 1 - int'(w_pos.index))));
            end
         end
      end
   end

   logic       s1_valid;
   logic       s1_is_hex;
   logic       s1_hl;
   logic [3:0] s1_nybble;
   logic [6:0] s1_char;
   logic [6:0] w_hex_char;

   lcd_hex_digit u_hex_digit (
      .nybble (s1_nybble),
      .ascii  (w_hex_char)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         s1_valid   <= 1'b0;
         s1_is_hex  <= 1'b0;
         s1_hl      <= 1'b0;
         s1_nybble  <= 4'd0;
         s1_char    <= CHAR_SPACE;
         char_valid <= 1'b0;
         character  <= CHAR_SPACE;
         highlight  <= 1'b0;
      end else begin
         s1_valid <= req_valid;
         if (req_valid) begin
            s1_is_hex <= w_is_hex;
            s1_hl     <= w_hl;
            s1_nybble <= w_nybble;
            s1_char   <= w_char;
         end
         char_valid <= s1_valid;
         if (s1_valid) begin
            character <= s1_is_hex ? w_hex_char : s1_char;
            highlight <= s1_hl;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_lcd_debug_panel.sv
// ============================================================================
// tb_lcd_debug_panel : directed self-checking bench for lcd_debug_panel
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_lcd_debug_panel;

   localparam int NV   = 3;
   localparam int VW   = 32;
   localparam int HOLD = 2;
`ifdef LCD_DEBUG_HIGHLIGHT_EN
   localparam bit HL_EN = 1'b1;
`else
   localparam bit HL_EN = 1'b0;
`endif

   logic          clock = 1'b0;
   logic          reset;
   logic          frame_start;
   logic          freeze;
   logic [NV*VW-1:0] values;
   logic          req_valid;
   logic [6:0]    column;
   logic [5:0]    row;
   logic          char_valid;
   logic [6:0]    character;
   logic          highlight;

   logic          req2_valid;
   logic [6:0]    column2;
   logic [5:0]    row2;
   logic [79:0]   values2;
   logic          char_valid2;
   logic [6:0]    character2;
   logic          highlight2;

   always #5 clock = ~clock;

   lcd_debug_panel #(
      .NUM_VALUES(NV), .VALUE_WIDTH(VW), .FIRST_ROW(2), .HOLD_FRAMES(HOLD)
   ) dut (
      .clock(clock), .reset(reset), .frame_start(frame_start), .freeze(freeze),
      .values(values), .req_valid(req_valid), .column(column), .row(row),
      .char_valid(char_valid), .character(character), .highlight(highlight)
   );

   lcd_debug_panel #(
      .NUM_VALUES(5), .VALUE_WIDTH(16), .FIRST_ROW(2), .HOLD_FRAMES(HOLD)
   ) dut2 (
      .clock(clock), .reset(reset), .frame_start(frame_start), .freeze(freeze),
      .values(values2), .req_valid(req2_valid), .column(column2), .row(row2),
      .char_valid(char_valid2), .character(character2), .highlight(highlight2)
   );

   int          checks   = 0;
   int          failures = 0;
   logic        prev_v;
   logic [6:0]  prev_c;
   logic        prev_h;
   logic [6:0]  last_c;
   logic        last_h;
   string       prev_tag;
   logic [VW-1:0] snap_m [NV];
   logic [7:0]  hc [NV];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < NV; k++) begin
         snap_m[k] = '0;
         hc[k]     = 8'd0;
      end
   endtask

   task automatic model_frame(input logic fz);
      if (!fz) begin
         for (int k = 0; k < NV; k++) begin
            if (values[k*VW +: VW] != snap_m[k]) hc[k] = 8'(HOLD);
            else if (hc[k] != 8'd0) hc[k] = hc[k] - 8'd1;
            snap_m[k] = values[k*VW +: VW];
         end
      end
   endtask

   function automatic logic exp_hl(input int k, input byte ch);
      if (k < 0 || ch == 8'h20) return 1'b0;
      return HL_EN && (hc[k] != 8'd0);
   endfunction

   // One cycle: drive a request, then check the output of the request from the previous call.
   task automatic issue(input logic v, input int r, input int c, input logic [6:0] ch,
                        input logic h, input logic rs);
      reset = rs; req_valid = v; row = 6'(r); column = 7'(c);
      @(posedge clock); #1;
      reset = 1'b0; req_valid = 1'b0;
      if (rs) begin
         chk("reset_valid", char_valid, 32'd0);
         chk("reset_char", character, 32'h20);
         chk("reset_hl", highlight, 32'd0);
         prev_v = 1'b0; last_c = 7'h20; last_h = 1'b0; prev_tag = "after_reset";
         model_reset();
      end else begin
         chk({prev_tag, "_valid"}, char_valid, 32'(prev_v));
         if (prev_v) begin
            last_c = prev_c;
            last_h = prev_h;
         end
         chk({prev_tag, "_char"}, character, 32'(last_c));
         chk({prev_tag, "_hl"}, highlight, 32'(last_h));
         prev_v = v; prev_c = ch; prev_h = h;
         prev_tag = $sformatf("r%0d_c%0d", r, c);
      end
   endtask

   task automatic flush();
      issue(1'b0, 0, 0, 7'h20, 1'b0, 1'b0);
   endtask

   task automatic frame(input logic fz);
      frame_start = 1'b1; freeze = fz;
      issue(1'b0, 0, 0, 7'h20, 1'b0, 1'b0);
      frame_start = 1'b0; freeze = 1'b0;
      model_frame(fz);
   endtask

   task automatic row_str(input int r, input string s, input int k);
      for (int i = 0; i < s.len(); i++)
         issue(1'b1, r, i, 7'(s[i]), exp_hl(k, s[i]), 1'b0);
   endtask

   task automatic dut2_check(input int r, input int c, input byte ch);
      req2_valid = 1'b1; row2 = 6'(r); column2 = 7'(c);
      @(posedge clock); #1;
      req2_valid = 1'b0;
      @(posedge clock); #1;
      chk($sformatf("dut2_r%0d_c%0d_valid", r, c), char_valid2, 32'd1);
      chk($sformatf("dut2_r%0d_c%0d_char", r, c), character2, 32'(ch));
   endtask

   initial begin
      reset = 1'b1; frame_start = 1'b0; freeze = 1'b0; req_valid = 1'b0;
      row = '0; column = '0; values = '0;
      req2_valid = 1'b0; row2 = '0; column2 = '0;
      values2 = {16'hBEEF, 48'h0, 16'h1234};
      prev_v = 1'b0; prev_c = 7'h20; prev_h = 1'b0; last_c = 7'h20; last_h = 1'b0;
      prev_tag = "init";
      model_reset();

      issue(1'b0, 0, 0, 7'h20, 1'b0, 1'b1);
      issue(1'b1, 2, 0, 7'h30, 1'b0, 1'b1);
      chk("dut2_reset_hl", highlight2, 32'd0);
      flush();

      // Title after three frames
      frame(1'b0); frame(1'b0); frame(1'b0);
      row_str(0, "Alice 4 \003 0003", -1);

      // Value 0 grouping and out-of-range rows
      values[31:0] = 32'h12345678;
      frame(1'b0);
      row_str(2, "1234 5678 ", 0);
      row_str(5, "  ", -1);
      row_str(1, "  ", -1);
      flush();

      // Narrow, five-value instance
      dut2_check(6, 0, "B");
      dut2_check(6, 1, "E");
      dut2_check(6, 2, "E");
      dut2_check(6, 3, "F");
      dut2_check(6, 4, " ");
      dut2_check(7, 0, " ");
      dut2_check(2, 3, "4");

      // Freeze holds the snapshot
      values[63:32] = 32'hFFFFFFFF;
      frame(1'b1);
      row_str(3, "0000 0000", 1);
      frame(1'b0);
      row_str(3, "FFFF FFFF", 1);

      // Change highlight decays over unchanged frames
      values[31:0] = 32'hA5A5A5A5;
      frame(1'b0); row_str(2, "A5A5 ", 0);
      frame(1'b0); row_str(2, "A5A5 ", 0);
      frame(1'b0); row_str(2, "A5A5 ", 0);
      frame(1'b0); row_str(2, "A5A5 ", 0);

      // Request in the frame_start cycle sees the old snapshot
      values[31:0] = 32'h0F0F0F0F;
      frame_start = 1'b1;
      issue(1'b1, 2, 1, 7'h35, exp_hl(0, "5"), 1'b0);
      frame_start = 1'b0;
      model_frame(1'b0);
      issue(1'b1, 2, 1, 7'h46, exp_hl(0, "F"), 1'b0);

      // Burst with gaps, reset mid-pipeline
      issue(1'b1, 0, 0, 7'h41, 1'b0, 1'b0);
      flush();
      issue(1'b1, 0, 1, 7'h6C, 1'b0, 1'b0);
      issue(1'b1, 3, 0, 7'h46, exp_hl(1, "F"), 1'b0);
      issue(1'b1, 0, 2, 7'h69, 1'b0, 1'b1);
      flush();
      issue(1'b1, 2, 0, 7'h30, 1'b0, 1'b0);
      issue(1'b1, 0, 4, 7'h65, 1'b0, 1'b0);
      issue(1'b1, 0, 13, 7'h30, 1'b0, 1'b0);
      flush();

      // Frame counter to 0xFFFF, then wrap
      frame_start = 1'b1;
      repeat (16'hFFFF) @(posedge clock);
      #1;
      frame_start = 1'b0;
      for (int k = 0; k < NV; k++) begin
         snap_m[k] = values[k*VW +: VW];
         hc[k]     = 8'd0;
      end
      row_str(0, "Alice 4 \003 FFFF", -1);
      frame(1'b0);
      row_str(0, "Alice 4 \003 0000", -1);
      row_str(2, "0F0F", 0);
      flush();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
